// File: rtl/systolic_pkg.sv
// systolic_pkg: shared geometry, job size and serializer FSM states for the systolic_4x4 feed path
package systolic_pkg;
  localparam int LANES = 4;
  localparam int OPW = 4;
  localparam int WORDS_PER_JOB = 8;
  localparam int FRAME_LEN = 4;
  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} opser_state_t;
endpackage

// File: rtl/opser_fifo.sv
// opser_fifo: synchronous word FIFO with combinational head read and registered occupancy count
module opser_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             data,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage array carries no reset; validity is tracked by count
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
endmodule

// File: rtl/operand_serializer.sv
// operand_serializer: buffers 4-lane operand words and streams 8-word jobs bit-serially (OPSER_MSB_FIRST_EN selects MSB-first frames)
module operand_serializer
  import systolic_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*OPW-1:0]   in_data,
  output logic                   start,
  output logic [LANES-1:0]       bit_inputs,
  output logic                   frame_first,
  output logic                   phase,
  output logic                   busy,
  output logic                   job_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(FRAME_LEN);
  opser_state_t state;
  logic [LANES*OPW-1:0] head, sreg;
  logic [CW-1:0] count;
  logic full, empty, pop, last_bit;
  logic [BW-1:0] bit_cnt;
  logic [2:0] word_cnt, word_nxt;
  function automatic logic [LANES-1:0] lane_bits(input logic [LANES*OPW-1:0] w, input logic [BW-1:0] k);
    logic [BW-1:0] kk;
`ifdef OPSER_MSB_FIRST_EN
    kk = ~k;
`else
    kk = k;
`endif
    for (int i = 0; i < LANES; i++) lane_bits[i] = w[i*OPW + int'(kk)];
  endfunction
  assign in_ready = !full;
  assign last_bit = bit_cnt == BW'(FRAME_LEN - 1);
  assign word_nxt = word_cnt + 3'd1;
  assign pop = !empty && (state == START || (state == SHIFT && last_bit && word_cnt != 3'd7));
  opser_fifo #(.DEPTH(DEPTH), .W(LANES*OPW)) u_fifo (
    .clk(clk), .reset(reset), .push(in_valid && in_ready), .pop(pop), .data(in_data),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  // job sequencer: every output is registered so the array sees clean edges
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      start <= 1'b0;
      bit_inputs <= '0;
      frame_first <= 1'b0;
      phase <= 1'b0;
      busy <= 1'b0;
      job_done <= 1'b0;
      sreg <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
    end else
      case (state)
        IDLE: if (count >= CW'(WORDS_PER_JOB)) begin
          state <= START;
          start <= 1'b1;
          busy <= 1'b1;
        end
        START: begin
          state <= SHIFT;
          start <= 1'b0;
          sreg <= head;
          bit_inputs <= lane_bits(head, '0);
          frame_first <= 1'b1;
          phase <= 1'b0;
          bit_cnt <= '0;
          word_cnt <= '0;
        end
        SHIFT: if (last_bit && word_cnt == 3'd7) begin
          state <= DONE;
          bit_inputs <= '0;
          frame_first <= 1'b0;
          phase <= 1'b0;
          job_done <= 1'b1;
        end else if (last_bit) begin
          sreg <= head;
          bit_inputs <= lane_bits(head, '0);
          frame_first <= 1'b1;
          phase <= word_nxt[2];
          bit_cnt <= '0;
          word_cnt <= word_nxt;
        end else begin
          bit_inputs <= lane_bits(sreg, bit_cnt + 1'b1);
          frame_first <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          job_done <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: directed checks of operand_serializer timing, data order, backpressure and reset (honours OPSER_MSB_FIRST_EN)
module tb_operand_serializer;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic start, frame_first, phase, busy, job_done;
  logic [3:0] bit_inputs;
  int n_chk = 0, n_fail = 0;
  logic [15:0] pend[$], sb[$];
  logic saw_full = 1'b0;
  logic [3:0] f0 [4];
  int waited;

  operand_serializer #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .bit_inputs(bit_inputs), .frame_first(frame_first), .phase(phase),
    .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_bits(input logic [15:0] w, input int k);
    int kk;
`ifdef OPSER_MSB_FIRST_EN
    kk = 3 - k;
`else
    kk = k;
`endif
    for (int i = 0; i < 4; i++) exp_bits[i] = w[4*i + kk];
  endfunction

  task automatic step();
    logic acc;
    @(negedge clk);
    in_valid = pend.size() > 0;
    in_data = '0;
    if (in_valid) in_data = pend[0];
    acc = in_valid && in_ready;
    if (in_valid && !in_ready) saw_full = 1'b1;
    @(posedge clk);
    if (acc) sb.push_back(pend.pop_front());
    #1;
  endtask

  task automatic run_job(input int budget, output int wt);
    logic [15:0] cur;
    wt = 0;
    do begin step(); wt++; end while (!start && wt < budget);
    chk("start_seen", start, 1);
    chk("busy_in_start", busy, 1);
    chk("bits_in_start", bit_inputs, 0);
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 4; k++) begin
        step();
        if (k == 0) begin
          chk("sb_has_word", sb.size() > 0, 1);
          cur = (sb.size() > 0) ? sb.pop_front() : 16'h0;
        end
        chk("bits", bit_inputs, exp_bits(cur, k));
        chk("frame_first", frame_first, k == 0);
        chk("phase", phase, w >= 4);
        chk("busy_shift", busy, 1);
        chk("start_low", start, 0);
        chk("done_low", job_done, 0);
        if (w == 0) f0[k] = bit_inputs;
      end
    step();
    chk("job_done", job_done, 1);
    chk("busy_done", busy, 1);
    chk("bits_done", bit_inputs, 0);
    chk("phase_done", phase, 0);
    step();
    chk("job_done_clear", job_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_outs", {start, bit_inputs, frame_first, phase, busy, job_done}, 0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    // job of known lane values
    for (int i = 0; i < 4; i++) pend.push_back(16'h4321);
    for (int i = 0; i < 4; i++) pend.push_back(16'hAAAA);
    run_job(40, waited);
    chk("latency_8th", waited, 9);
`ifdef OPSER_MSB_FIRST_EN
    chk("f0_k0", f0[0], 4'b0000);
    chk("f0_k1", f0[1], 4'b1000);
    chk("f0_k2", f0[2], 4'b0110);
    chk("f0_k3", f0[3], 4'b0101);
`else
    chk("f0_k0", f0[0], 4'b0101);
    chk("f0_k1", f0[1], 4'b0110);
    chk("f0_k2", f0[2], 4'b1000);
    chk("f0_k3", f0[3], 4'b0000);
`endif
    // seven words must not start a job
    for (int i = 0; i < 7; i++) pend.push_back(16'h1000 + 16'(i * 'h111));
    repeat (7) step();
    for (int c = 0; c < 50; c++) begin
      step();
      chk("no_start_7", start, 0);
      chk("no_busy_7", busy, 0);
    end
    pend.push_back(16'hBEEF);
    run_job(10, waited);
    chk("latency_8th_late", waited, 2);
    // 24 words streamed back-to-back: fills the FIFO, mixes push with pop
    saw_full = 1'b0;
    for (int i = 0; i < 24; i++) pend.push_back(16'(i * 'h0123) ^ 16'h5A0F);
    run_job(20, waited);
    chk("b2b_first", waited, 9);
    run_job(10, waited);
    chk("b2b_gap", waited, 1);
    run_job(10, waited);
    chk("b2b_gap2", waited, 1);
    chk("saw_full", saw_full, 1);
    chk("all_pushed", pend.size(), 0);
    chk("all_consumed", sb.size(), 0);
    // reset in the middle of a job
    for (int i = 0; i < 8; i++) pend.push_back(16'hF00D + 16'(i));
    waited = 0;
    do begin step(); waited++; end while (!start && waited < 20);
    chk("rst_job_start", start, 1);
    repeat (11) step();
    chk("rst_job_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_outs", {start, bit_inputs, frame_first, phase, busy, job_done}, 0);
    chk("async_rst_ready", in_ready, 1);
    pend.delete();
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("no_done_after_rst", job_done, 0);
      chk("idle_after_rst", busy, 0);
    end
    // fresh job after reset
    for (int i = 0; i < 8; i++) pend.push_back(16'($urandom));
    run_job(20, waited);
    chk("fresh_latency", waited, 9);
    // frame order probe on lane 0
    pend.push_back(16'h0008);
    for (int i = 0; i < 7; i++) pend.push_back(16'h0000);
    run_job(20, waited);
`ifdef OPSER_MSB_FIRST_EN
    chk("lane0_order", {f0[0][0], f0[1][0], f0[2][0], f0[3][0]}, 4'b1000);
`else
    chk("lane0_order", {f0[0][0], f0[1][0], f0[2][0], f0[3][0]}, 4'b0001);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
